// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between an
// instruction-fetch requester (r0) and a load/store requester (r1).
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state, state_nx;
  logic              last, last_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              take, take_id;
  logic              win_id, win_we;
  logic              wait_end;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign sel_we    = take_id ? r1_we    : r0_we;
  assign sel_addr  = take_id ? r1_addr  : r0_addr;
  assign sel_wdata = take_id ? r1_wdata : r0_wdata;
  assign wait_end  = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    take     = 1'b0;
    take_id  = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester that did not win last time goes first
        if (r0_req && (!r1_req || last)) begin
          take    = 1'b1;
          take_id = 1'b0;
        end else if (r1_req) begin
          take    = 1'b1;
          take_id = 1'b1;
        end
        if (take) begin
          state_nx = ACCESS;
          last_nx  = take_id;
        end
      end
      ACCESS: begin
        state_nx = WAIT;
        cnt_nx   = LAT_M1;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = DONE;
        else             cnt_nx   = cnt - 4'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-state decisions so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= 4'd0;
      win_id    <= 1'b0;
      win_we    <= 1'b0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      cnt     <= cnt_nx;
      r0_gnt  <= take & ~take_id;
      r1_gnt  <= take & take_id;
      mem_en  <= take;
      mem_we  <= take & sel_we;
      r0_done <= wait_end & ~win_id;
      r1_done <= wait_end & win_id;
      busy    <= (state_nx != IDLE);
      if (take) begin
        win_id    <= take_id;
        win_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      // Writes complete with a done pulse but leave both rdata registers untouched
      if (wait_end && !win_we) begin
        if (win_id) r1_rdata <= mem_rdata;
        else        r0_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15) with latency-accurate
// memory models; instance 0 is also checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int NI   = 3;
  localparam int LAT0 = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_clr = 1'b1;
  logic          r0_req [NI], r0_we [NI], r1_req [NI], r1_we [NI];
  logic [AW-1:0] r0_addr [NI], r1_addr [NI];
  logic [DW-1:0] r0_wdata [NI], r1_wdata [NI];
  logic          r0_gnt [NI], r0_done [NI], r1_gnt [NI], r1_done [NI];
  logic [DW-1:0] r0_rdata [NI], r1_rdata [NI];
  logic          mem_en [NI], mem_we [NI], busy [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] mem_wdata [NI];

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rd [2];
  logic          m_last;
  item_t         q0 [$];
  item_t         q1 [$];
  int            done_log1 [$];
  int            gnt_log [$];

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    if (b == 8'h10) return 32'hDEADBEEF;
    return {b, ~b, b ^ 8'h3c, 8'h77};
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 15;
    logic [DW-1:0] wr_mem [256];
    logic          wr_v [256];
    logic [DW-1:0] pd [16];
    logic          pv [16];
    logic [DW-1:0] mrd;

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) wr_v[i] <= 1'b0;
      end else if (mem_en[k] && mem_we[k]) begin
        wr_mem[mem_addr[k][7:0]] <= mem_wdata[k];
        wr_v[mem_addr[k][7:0]]   <= 1'b1;
      end
      pd[0] <= wr_v[mem_addr[k][7:0]] ? wr_mem[mem_addr[k][7:0]] : init_word(int'(mem_addr[k][7:0]));
      pv[0] <= mem_en[k] && !mem_we[k] && !mem_clr;
      for (int i = 1; i < 16; i++) begin
        pd[i] <= pd[i-1];
        pv[i] <= pv[i-1] && !mem_clr;
      end
    end
    assign mrd = pv[L-1] ? pd[L-1] : 32'h0BADF00D;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req[k]), .r0_we(r0_we[k]), .r0_addr(r0_addr[k]), .r0_wdata(r0_wdata[k]),
      .r0_gnt(r0_gnt[k]), .r0_done(r0_done[k]), .r0_rdata(r0_rdata[k]),
      .r1_req(r1_req[k]), .r1_we(r1_we[k]), .r1_addr(r1_addr[k]), .r1_wdata(r1_wdata[k]),
      .r1_gnt(r1_gnt[k]), .r1_done(r1_done[k]), .r1_rdata(r1_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
      .mem_rdata(mrd), .busy(busy[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, "_gnt0"},  32'(r0_gnt[k]),  32'h0);
    chk({tag, "_gnt1"},  32'(r1_gnt[k]),  32'h0);
    chk({tag, "_done0"}, 32'(r0_done[k]), 32'h0);
    chk({tag, "_done1"}, 32'(r1_done[k]), 32'h0);
    chk({tag, "_rd0"},   r0_rdata[k],     32'h0);
    chk({tag, "_rd1"},   r1_rdata[k],     32'h0);
    chk({tag, "_men"},   32'(mem_en[k]),  32'h0);
    chk({tag, "_mwe"},   32'(mem_we[k]),  32'h0);
    chk({tag, "_madr"},  32'(mem_addr[k]), 32'h0);
    chk({tag, "_mwd"},   mem_wdata[k],    32'h0);
    chk({tag, "_busy"},  32'(busy[k]),    32'h0);
  endtask

  task automatic set_req(input int r, input logic rq, input item_t it);
    if (r == 0) begin
      r0_req[0] = rq; r0_we[0] = it.we; r0_addr[0] = it.addr; r0_wdata[0] = it.wdata;
    end else begin
      r1_req[0] = rq; r1_we[0] = it.we; r1_addr[0] = it.addr; r1_wdata[0] = it.wdata;
    end
  endtask

  // Transaction-level model of instance 0: a grant decided in an idle cycle c
  // yields gnt at c+1, done at c+LAT+2, and the arbiter samples again at c+LAT+3.
  task automatic run_model(input int gap_pct, input int max_cyc);
    int            busy_until;
    int            g;
    int            d;
    logic          w_id, w_we, win_ok, win, gobs, finished;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata, w_rdata;
    logic          hold [2];
    logic          seen [2];
    item_t         it;
    busy_until = 0; g = -1; d = -1;
    w_id = 1'b0; w_we = 1'b0; w_addr = '0; w_wdata = '0; w_rdata = '0;
    finished = 1'b0;
    hold[0] = 1'b0; hold[1] = 1'b0; seen[0] = 1'b0; seen[1] = 1'b0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      @(negedge clk);
      if (c == d && !w_we) exp_rd[w_id] = w_rdata;
      chk("m_gnt0",  32'(r0_gnt[0]),  32'(c == g && !w_id));
      chk("m_gnt1",  32'(r1_gnt[0]),  32'(c == g && w_id));
      chk("m_done0", 32'(r0_done[0]), 32'(c == d && !w_id));
      chk("m_done1", 32'(r1_done[0]), 32'(c == d && w_id));
      chk("m_busy",  32'(busy[0]),    32'(g >= 0 && c >= g && c <= d));
      chk("m_men",   32'(mem_en[0]),  32'(c == g));
      if (c == g) begin
        chk("m_mwe",  32'(mem_we[0]),   32'(w_we));
        chk("m_madr", 32'(mem_addr[0]), 32'(w_addr));
        chk("m_mwd",  mem_wdata[0],     w_wdata);
      end
      chk("m_rd0", r0_rdata[0], exp_rd[0]);
      chk("m_rd1", r1_rdata[0], exp_rd[1]);
      if (r1_done[0]) done_log1.push_back(c);
      if (r0_gnt[0]) gnt_log.push_back(0);
      if (r1_gnt[0]) gnt_log.push_back(1);
      for (int r = 0; r < 2; r++) begin
        gobs = (r == 0) ? r0_gnt[0] : r1_gnt[0];
        if (hold[r] && seen[r]) begin
          hold[r] = 1'b0; seen[r] = 1'b0;
          set_req(r, 1'b0, '0);
        end else if (hold[r] && gobs) begin
          seen[r] = 1'b1;
        end
        if (!hold[r] && ((r == 0) ? q0.size() : q1.size()) > 0 &&
            int'($urandom_range(99)) >= gap_pct) begin
          it = (r == 0) ? q0.pop_front() : q1.pop_front();
          set_req(r, 1'b1, it);
          hold[r] = 1'b1;
        end
      end
      if (c >= busy_until) begin
        win_ok = r0_req[0] || r1_req[0];
        win    = (r0_req[0] && r1_req[0]) ? !m_last : r1_req[0];
        if (win_ok) begin
          g = c + 1; d = c + LAT0 + 2; busy_until = c + LAT0 + 3;
          m_last  = win;
          w_id    = win;
          w_we    = win ? r1_we[0]    : r0_we[0];
          w_addr  = win ? r1_addr[0]  : r0_addr[0];
          w_wdata = win ? r1_wdata[0] : r0_wdata[0];
          if (w_we) ref_mem[w_addr[7:0]] = w_wdata;
          else      w_rdata = ref_mem[w_addr[7:0]];
        end
      end
      if (c >= busy_until && !hold[0] && !hold[1] && q0.size() == 0 && q1.size() == 0)
        finished = 1'b1;
    end
    chk("m_finished", 32'(finished), 32'h1);
  endtask

  function automatic item_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    item_t it;
    it.we = we; it.addr = a; it.wdata = wd;
    return it;
  endfunction

  initial begin
    int            first;
    logic [DW-1:0] r1_before;
    for (int k = 0; k < NI; k++) begin
      r0_req[k] = 1'b0; r0_we[k] = 1'b0; r0_addr[k] = '0; r0_wdata[k] = '0;
      r1_req[k] = 1'b0; r1_we[k] = 1'b0; r1_addr[k] = '0; r1_wdata[k] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_rd[0] = '0; exp_rd[1] = '0;
    m_last = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) check_zero(k, "rst");
    rst_n = 1'b1; mem_clr = 1'b0;

    // r0 read of 0x0010 on every latency build
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      r0_req[k] = 1'b1; r0_we[k] = 1'b0; r0_addr[k] = 16'h0010;
    end
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("t1_gnt0",  32'(r0_gnt[k]),  32'(cyc == 1));
        chk("t1_men",   32'(mem_en[k]),  32'(cyc == 1));
        chk("t1_done0", 32'(r0_done[k]), 32'(cyc == lat_of(k) + 2));
        chk("t1_busy",  32'(busy[k]),    32'(cyc >= 1 && cyc <= lat_of(k) + 2));
        chk("t1_rd0",   r0_rdata[k],     (cyc >= lat_of(k) + 2) ? 32'hDEADBEEF : 32'h0);
        chk("t1_r1",    32'(r1_gnt[k]) | 32'(r1_done[k]) | r1_rdata[k], 32'h0);
        if (cyc == 1) begin
          chk("t1_madr", 32'(mem_addr[k]), 32'h0010);
          chk("t1_mwe",  32'(mem_we[k]),   32'h0);
        end
        if (cyc == 2) r0_req[k] = 1'b0;
      end
    end
    exp_rd[0] = 32'hDEADBEEF;
    m_last = 1'b0;

    // both requesters continuously busy: grants must alternate
    gnt_log.delete();
    first = m_last ? 0 : 1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 16'($urandom_range(255)), '0));
      q1.push_back(mk(1'b0, 16'($urandom_range(255)), '0));
    end
    run_model(0, 200);
    chk("t2_ngnt", 32'(gnt_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("t2_alt", 32'((i < gnt_log.size()) ? gnt_log[i] : -1), 32'((first + i) % 2));

    // r1 write then r0 read-back of the same word
    r1_before = exp_rd[1];
    q1.push_back(mk(1'b1, 16'h0044, 32'h12345678));
    run_model(0, 50);
    q0.push_back(mk(1'b0, 16'h0044, '0));
    run_model(0, 50);
    chk("t3_rd0", r0_rdata[0], 32'h12345678);
    chk("t3_rd1_hold", r1_rdata[0], r1_before);

    // r1 alone, back to back
    done_log1.delete();
    for (int i = 0; i < 3; i++) q1.push_back(mk(1'b0, 16'($urandom_range(255)), '0));
    run_model(0, 60);
    chk("t4_cnt", 32'(done_log1.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t4_done", 32'((i < done_log1.size()) ? done_log1[i] : -1), 32'(4 + 5 * i));

    // random mixed traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0)
        q0.push_back(mk(1'($urandom_range(1)), 16'($urandom_range(31)), $urandom));
      else
        q1.push_back(mk(1'($urandom_range(1)), 16'($urandom_range(31)), $urandom));
    end
    run_model(50, 2000);

    // reset during WAIT abandons the transaction
    @(negedge clk);
    r0_req[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 16'h0020;
    @(negedge clk);
    chk("t5_gnt0", 32'(r0_gnt[0]), 32'h1);
    @(negedge clk);
    r0_req[0] = 1'b0;
    chk("t5_busy", 32'(busy[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_zero(0, "t5_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_nodone", 32'(r0_done[0]) | 32'(busy[0]), 32'h0);
    end
    rst_n = 1'b1;
    m_last = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    gnt_log.delete();
    q0.push_back(mk(1'b0, 16'h0021, '0));
    q1.push_back(mk(1'b0, 16'h0022, '0));
    run_model(0, 60);
    chk("t5_first", 32'((gnt_log.size() > 0) ? gnt_log[0] : -1), 32'h0);
    chk("t5_second", 32'((gnt_log.size() > 1) ? gnt_log[1] : -1), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
